pll_lock_sequencer: RTL and testbench



---
 rtl/pll_lock_sequencer_if.sv | 15 +
 rtl/pll_lock_sequencer.sv | 114 +++++++++++
 tb/tb_pll_lock_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if: control/status bundle between the system controller and the PLL lock sequencer
// Signals: start, pll_lock (to sequencer); pll_en, ready, lock_lost, error, retry_cnt[3:0], state[2:0] (from sequencer)
// Modports: master = controller/PLL side, slave = sequencer side
interface pll_lock_sequencer_if;
    logic       start;
    logic       pll_lock;
    logic       pll_en;
    logic       ready;
    logic       lock_lost;
    logic       error;
    logic [3:0] retry_cnt;
    logic [2:0] state;
    modport master (output start, pll_lock, input pll_en, ready, lock_lost, error, retry_cnt, state);
    modport slave  (input start, pll_lock, output pll_en, ready, lock_lost, error, retry_cnt, state);
endinterface

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives PLL enable, qualifies a synchronized lock, retries with power-cycling, ends in sticky fault
// Ports: clk_i controller clock; rst_i synchronous active-high reset;
//        ctl (slave): start level request, pll_lock async lock in; pll_en, ready, lock_lost pulse,
//        error sticky fault, retry_cnt retries used, state (OFF=0 PWRUP=1 RUN=2 BACKOFF=3 FAULT=4) out
module pll_lock_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int OFF_CYCLES    = 8,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pll_lock_sequencer_if.slave  ctl
);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int OW = $clog2(OFF_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] S_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OFF_CYCLES - 1);
    localparam logic [3:0]    R_MAX  = 4'(MAX_RETRIES);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || STABLE_CYCLES < 1 || STABLE_CYCLES >= LOCK_TIMEOUT ||
        OFF_CYCLES < 1 || MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_bad_params
        $fatal(1, "%m: illegal pll_lock_sequencer parameters");
    end

    typedef enum logic [2:0] {OFF = 3'd0, PWRUP = 3'd1, RUN = 3'd2, BACKOFF = 3'd3, FAULT = 3'd4} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [TW-1:0]          timer_q, stab_q;
    logic [OW-1:0]          off_q;
    logic [3:0]             retry_q;
    logic                   pll_en_q, ready_q, lock_lost_q, error_q;
    logic                   lock_s, stab_done, leave;

    assign lock_s    = sync_q[SYNC_STAGES-1];
    // Stable completion in the timeout cycle takes precedence over the timeout.
    assign stab_done = state_q == PWRUP && lock_s && stab_q == S_LAST;
    assign leave     = state_q == PWRUP ? !stab_done && timer_q == T_LAST : state_q == RUN && !lock_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= OFF;
            sync_q      <= '0;
            timer_q     <= '0;
            stab_q      <= '0;
            off_q       <= '0;
            retry_q     <= '0;
            pll_en_q    <= 1'b0;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], ctl.pll_lock};
            lock_lost_q <= 1'b0;
            if (!ctl.start) begin
                state_q  <= OFF;
                timer_q  <= '0;
                stab_q   <= '0;
                off_q    <= '0;
                retry_q  <= '0;
                pll_en_q <= 1'b0;
                ready_q  <= 1'b0;
                error_q  <= 1'b0;
            end else if (leave) begin
                // Retry decision: power-cycle via BACKOFF or give up once the budget is spent.
                state_q     <= retry_q == R_MAX ? FAULT : BACKOFF;
                retry_q     <= retry_q == R_MAX ? retry_q : retry_q + 1'b1;
                error_q     <= retry_q == R_MAX;
                lock_lost_q <= state_q == RUN;
                pll_en_q    <= 1'b0;
                ready_q     <= 1'b0;
                off_q       <= '0;
            end else begin
                case (state_q)
                    OFF: begin
                        state_q  <= PWRUP;
                        pll_en_q <= 1'b1;
                        timer_q  <= '0;
                        stab_q   <= '0;
                    end
                    PWRUP: begin
                        timer_q <= timer_q + 1'b1;
                        stab_q  <= lock_s ? stab_q + 1'b1 : '0;
                        if (stab_done) begin
                            state_q <= RUN;
                            ready_q <= 1'b1;
                            retry_q <= '0;
                        end
                    end
                    BACKOFF: begin
                        off_q <= off_q + 1'b1;
                        if (off_q == O_LAST) begin
                            state_q  <= PWRUP;
                            pll_en_q <= 1'b1;
                            timer_q  <= '0;
                            stab_q   <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ctl.state     = state_q;
    assign ctl.pll_en    = pll_en_q;
    assign ctl.ready     = ready_q;
    assign ctl.lock_lost = lock_lost_q;
    assign ctl.error     = error_q;
    assign ctl.retry_cnt = retry_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;

    pll_lock_sequencer_if bus();

    pll_lock_sequencer #(
        .SYNC_STAGES(2), .STABLE_CYCLES(4), .LOCK_TIMEOUT(32), .OFF_CYCLES(8), .MAX_RETRIES(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .ctl(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input int st, input int en, input int rdy, input int ll, input int er, input int rc);
        check({tag, ".state"}, 32'(bus.state), st);
        check({tag, ".pll_en"}, 32'(bus.pll_en), en);
        check({tag, ".ready"}, 32'(bus.ready), rdy);
        check({tag, ".lock_lost"}, 32'(bus.lock_lost), ll);
        check({tag, ".error"}, 32'(bus.error), er);
        check({tag, ".retry_cnt"}, 32'(bus.retry_cnt), rc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pll_lock = 1'b0;
        step(3);
        outs("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        bus.start = 1'b1;
        step(1);
        outs("pwrup", 1, 1, 0, 0, 0, 0);
        bus.pll_lock = 1'b1;
        step(5);
        outs("qualifying", 1, 1, 0, 0, 0, 0);
        step(1);
        outs("ready", 2, 1, 1, 0, 0, 0);
        bus.pll_lock = 1'b0;
        step(2);
        outs("loss_sync", 2, 1, 1, 0, 0, 0);
        step(1);
        outs("lock_lost", 3, 0, 0, 1, 0, 1);
        step(1);
        outs("backoff", 3, 0, 0, 0, 0, 1);
        step(6);
        outs("backoff_end", 3, 0, 0, 0, 0, 1);
        step(1);
        outs("repwrup", 1, 1, 0, 0, 0, 1);
        bus.pll_lock = 1'b1;
        step(5);
        outs("relock_wait", 1, 1, 0, 0, 0, 1);
        step(1);
        outs("relock", 2, 1, 1, 0, 0, 0);
        bus.pll_lock = 1'b0;
        step(2);
        outs("run_pre", 2, 1, 1, 0, 0, 0);
        bus.start = 1'b0;
        step(1);
        outs("stop_run", 0, 0, 0, 0, 0, 0);
        step(1);
        outs("stop_run2", 0, 0, 0, 0, 0, 0);
        bus.start = 1'b1;
        step(1);
        outs("g_pwrup", 1, 1, 0, 0, 0, 0);
        bus.pll_lock = 1'b1;
        step(3);
        bus.pll_lock = 1'b0;
        step(1);
        bus.pll_lock = 1'b1;
        step(2);
        outs("g_restart", 1, 1, 0, 0, 0, 0);
        step(3);
        outs("g_wait", 1, 1, 0, 0, 0, 0);
        step(1);
        outs("g_ready", 2, 1, 1, 0, 0, 0);
        bus.start = 1'b0;
        bus.pll_lock = 1'b0;
        step(3);
        outs("off", 0, 0, 0, 0, 0, 0);
        bus.start = 1'b1;
        step(1);
        outs("t1_start", 1, 1, 0, 0, 0, 0);
        step(31);
        outs("t1_last", 1, 1, 0, 0, 0, 0);
        step(1);
        outs("t1_timeout", 3, 0, 0, 0, 0, 1);
        step(7);
        outs("t1_gap", 3, 0, 0, 0, 0, 1);
        step(1);
        outs("t2_start", 1, 1, 0, 0, 0, 1);
        step(31);
        outs("t2_last", 1, 1, 0, 0, 0, 1);
        step(1);
        outs("t2_timeout", 3, 0, 0, 0, 0, 2);
        step(8);
        outs("t3_start", 1, 1, 0, 0, 0, 2);
        step(31);
        outs("t3_last", 1, 1, 0, 0, 0, 2);
        step(1);
        outs("fault", 4, 0, 0, 0, 1, 2);
        step(5);
        outs("fault_hold", 4, 0, 0, 0, 1, 2);
        bus.start = 1'b0;
        step(1);
        outs("fault_clear", 0, 0, 0, 0, 0, 0);
        bus.start = 1'b1;
        step(1);
        outs("restart", 1, 1, 0, 0, 0, 0);
        step(32);
        outs("b_enter", 3, 0, 0, 0, 0, 1);
        step(3);
        bus.start = 1'b0;
        step(1);
        outs("stop_backoff", 0, 0, 0, 0, 0, 0);
        bus.start = 1'b1;
        step(10);
        outs("p_mid", 1, 1, 0, 0, 0, 0);
        bus.start = 1'b0;
        step(1);
        outs("stop_pwrup", 0, 0, 0, 0, 0, 0);
        bus.start = 1'b1;
        step(5);
        rst = 1'b1;
        step(1);
        outs("rst_mid", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(1);
        outs("post_rst", 1, 1, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
